// File: rtl/alu_pkg.sv
// Definitions shared by the ALU and its result checker: opcodes, flag bit
// positions, the response record and a flag-vector builder.
package alu_pkg;

  localparam logic [6:0] OP_ADD   = 7'd0;
  localparam logic [6:0] OP_SUB   = 7'd1;
  localparam logic [6:0] OP_AND   = 7'd2;
  localparam logic [6:0] OP_OR    = 7'd3;
  localparam logic [6:0] OP_XOR   = 7'd4;
  localparam logic [6:0] OP_NOT   = 7'd5;
  localparam logic [6:0] OP_SHL   = 7'd6;
  localparam logic [6:0] OP_SHR   = 7'd7;
  localparam logic [6:0] OP_SRA   = 7'd8;
  localparam logic [6:0] OP_PASSB = 7'd9;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_V = 2;
  localparam int FLG_C = 3;
  localparam int FLG_P = 4;

  localparam int ALU_W = 32;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             carry;
    logic [4:0]       flags;
  } alu_resp_t;

  function automatic logic [4:0] pack_flags(input logic z, input logic n, input logic v,
                                            input logic c, input logic p);
    logic [4:0] f;
    f        = '0;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    f[FLG_V] = v;
    f[FLG_C] = c;
    f[FLG_P] = p;
    return f;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: expected result, carry and flags for one
// {opcode, A, B}, plus whether the opcode is one the checker understands.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [6:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [4:0]       flags,
  output logic             supported
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] shl_ext;
  logic [WIDTH:0] shr_ext;
  logic [WIDTH:0] sra_ext;
  logic [SHW-1:0] shamt;
  logic           ovf;

  // One guard bit on the shifts catches the last bit shifted out; with a
  // zero shift amount that guard bit is 0, which is the required carry.
  assign shamt   = b[SHW-1:0];
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign shl_ext = {1'b0, a} << shamt;
  assign shr_ext = {a, 1'b0} >> shamt;
  assign sra_ext = $signed({a, 1'b0}) >>> shamt;

  always_comb begin
    result    = '0;
    carry     = 1'b0;
    ovf       = 1'b0;
    supported = 1'b1;
    case (opcode)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = ~diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOT:   result = ~a;
      OP_SHL: begin
        result = shl_ext[WIDTH-1:0];
        carry  = shl_ext[WIDTH];
      end
      OP_SHR: begin
        result = shr_ext[WIDTH:1];
        carry  = shr_ext[0];
      end
      OP_SRA: begin
        result = sra_ext[WIDTH:1];
        carry  = sra_ext[0];
      end
      OP_PASSB: result = b;
      default:  supported = 1'b0;
    endcase
    flags = pack_flags(result == '0, result[WIDTH-1], ovf, carry, ~^result);
  end

endmodule

// File: rtl/alu_result_checker.sv
// Two-stage ALU response checker: stage 1 captures a sample and its golden
// result, stage 2 compares, updates saturating counters and the first-fail capture.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int         WIDTH        = 32,
  parameter int         CNT_W        = 16,
  parameter logic [4:0] FLAG_MASK    = 5'b00011,
  parameter bit         STOP_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [6:0]       opcode,
  input  logic [WIDTH-1:0] aluOut,
  input  logic             carry,
  input  logic [4:0]       flags,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] skip_count,
  output logic             fail_valid,
  output logic [6:0]       fail_opcode,
  output logic [WIDTH-1:0] fail_expected,
  output logic [WIDTH-1:0] fail_actual,
  output logic             halted
);
  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t           state;
  logic             accept;
  logic [WIDTH-1:0] ref_result;
  logic             ref_carry;
  logic [4:0]       ref_flags;
  logic             ref_supported;

  logic             s1_valid;
  logic             s1_supported;
  logic [6:0]       s1_opcode;
  logic [WIDTH-1:0] s1_exp_result;
  logic             s1_exp_carry;
  logic [4:0]       s1_exp_flags;
  logic [WIDTH-1:0] s1_act_result;
  logic             s1_act_carry;
  logic [4:0]       s1_act_flags;
  logic             s2_match;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready is a function of FSM state alone and never looks at in_valid.
  assign in_ready = (state == ST_RUN);
  assign accept   = in_valid && in_ready;
  assign halted   = (state == ST_HALT);

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .opcode    (opcode),
    .a         (A),
    .b         (B),
    .result    (ref_result),
    .carry     (ref_carry),
    .flags     (ref_flags),
    .supported (ref_supported)
  );

  assign s2_match = (s1_exp_result == s1_act_result) && (s1_exp_carry == s1_act_carry) &&
                    (((s1_exp_flags ^ s1_act_flags) & FLAG_MASK) == 5'b0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      s1_valid      <= 1'b0;
      s1_supported  <= 1'b0;
      s1_opcode     <= '0;
      s1_exp_result <= '0;
      s1_exp_carry  <= 1'b0;
      s1_exp_flags  <= '0;
      s1_act_result <= '0;
      s1_act_carry  <= 1'b0;
      s1_act_flags  <= '0;
      pass_count    <= '0;
      fail_count    <= '0;
      skip_count    <= '0;
      fail_valid    <= 1'b0;
      fail_opcode   <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else if (clear) begin
      // Clear wins over any stage-2 result and drops the sample offered now.
      state         <= ST_RUN;
      s1_valid      <= 1'b0;
      pass_count    <= '0;
      fail_count    <= '0;
      skip_count    <= '0;
      fail_valid    <= 1'b0;
      fail_opcode   <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_supported  <= ref_supported;
        s1_opcode     <= opcode;
        s1_exp_result <= ref_result;
        s1_exp_carry  <= ref_carry;
        s1_exp_flags  <= ref_flags;
        s1_act_result <= aluOut;
        s1_act_carry  <= carry;
        s1_act_flags  <= flags;
      end
      if (s1_valid) begin
        if (!s1_supported) begin
          if (skip_count != '1) skip_count <= skip_count + CNT_W'(1);
        end else if (s2_match) begin
          if (pass_count != '1) pass_count <= pass_count + CNT_W'(1);
        end else begin
          if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
          if (!fail_valid) begin
            fail_valid    <= 1'b1;
            fail_opcode   <= s1_opcode;
            fail_expected <= s1_exp_result;
            fail_actual   <= s1_act_result;
          end
          if (STOP_ON_FAIL) state <= ST_HALT;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: a halting 16-bit-counter instance and a
// non-halting 4-bit-counter instance share stimulus against a queue-based model.
module tb_alu_result_checker;

  typedef struct {
    int          inst;
    int          kind;   // 0 pass, 1 fail, 2 skip
    logic [6:0]  op;
    logic [31:0] exp;
    logic [31:0] act;
  } sample_t;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [6:0]  op_in;
  logic [31:0] res_in;
  logic        carry_in;
  logic [4:0]  flags_in;

  logic        ready0, ready1, fv0, fv1, halt0, halt1;
  logic [15:0] pass0, fail0, skip0;
  logic [3:0]  pass1, fail1, skip1;
  logic [6:0]  fop0, fop1;
  logic [31:0] fexp0, fexp1, fact0, fact1;

  logic [31:0] o_pass[2], o_fail[2], o_skip[2], o_fexp[2], o_fact[2];
  logic [6:0]  o_fop[2];
  logic        o_fv[2], o_halt[2], o_ready[2];

  int          m_pass[2], m_fail[2], m_skip[2];
  bit          m_fv[2], m_halt[2];
  logic [6:0]  m_fop[2];
  logic [31:0] m_fexp[2], m_fact[2];
  sample_t     pend_q[$];
  sample_t     cur;
  int          total = 0;
  int          bad = 0;

  alu_result_checker u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ready0),
    .A(a_in), .B(b_in), .opcode(op_in), .aluOut(res_in), .carry(carry_in), .flags(flags_in),
    .pass_count(pass0), .fail_count(fail0), .skip_count(skip0), .fail_valid(fv0),
    .fail_opcode(fop0), .fail_expected(fexp0), .fail_actual(fact0), .halted(halt0)
  );

  alu_result_checker #(.CNT_W(4), .STOP_ON_FAIL(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ready1),
    .A(a_in), .B(b_in), .opcode(op_in), .aluOut(res_in), .carry(carry_in), .flags(flags_in),
    .pass_count(pass1), .fail_count(fail1), .skip_count(skip1), .fail_valid(fv1),
    .fail_opcode(fop1), .fail_expected(fexp1), .fail_actual(fact1), .halted(halt1)
  );

  assign o_pass[0] = 32'(pass0);  assign o_pass[1] = 32'(pass1);
  assign o_fail[0] = 32'(fail0);  assign o_fail[1] = 32'(fail1);
  assign o_skip[0] = 32'(skip0);  assign o_skip[1] = 32'(skip1);
  assign o_fexp[0] = fexp0;       assign o_fexp[1] = fexp1;
  assign o_fact[0] = fact0;       assign o_fact[1] = fact1;
  assign o_fop[0]  = fop0;        assign o_fop[1]  = fop1;
  assign o_fv[0]   = fv0;         assign o_fv[1]   = fv1;
  assign o_halt[0] = halt0;       assign o_halt[1] = halt1;
  assign o_ready[0] = ready0;     assign o_ready[1] = ready1;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_zero(input int i);
    m_pass[i] = 0; m_fail[i] = 0; m_skip[i] = 0;
    m_fv[i] = 1'b0; m_halt[i] = 1'b0;
    m_fop[i] = '0; m_fexp[i] = '0; m_fact[i] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    a_in = '0; b_in = '0; op_in = '0; res_in = '0; carry_in = 1'b0; flags_in = '0;
    model_zero(0); model_zero(1);
    pend_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_calc(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic c, output logic [4:0] f,
                                   output bit sup);
    logic [63:0] wide;
    longint      s;
    int          sh;
    logic        v;
    sup = 1'b1; c = 1'b0; v = 1'b0; r = '0;
    sh  = int'(b[4:0]);
    case (op)
      7'd0: begin
        wide = {32'h0, a} + {32'h0, b};
        r = wide[31:0]; c = wide[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s != longint'($signed(r)));
      end
      7'd1: begin
        r = a - b; c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s != longint'($signed(r)));
      end
      7'd2: r = a & b;
      7'd3: r = a | b;
      7'd4: r = a ^ b;
      7'd5: r = ~a;
      7'd6: begin r = a << sh; c = (sh == 0) ? 1'b0 : a[32 - sh]; end
      7'd7: begin r = a >> sh; c = (sh == 0) ? 1'b0 : a[sh - 1]; end
      7'd8: begin r = 32'($signed(a) >>> sh); c = (sh == 0) ? 1'b0 : a[sh - 1]; end
      7'd9: r = b;
      default: sup = 1'b0;
    endcase
    f = {~^r, c, v, r[31], (r == 32'h0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_raw(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic c, input logic [4:0] f);
    logic [31:0] er; logic ec; logic [4:0] ef; bit sup;
    in_valid = 1'b1; op_in = op; a_in = a; b_in = b; res_in = res; carry_in = c; flags_in = f;
    ref_calc(op, a, b, er, ec, ef, sup);
    if (!sup) cur.kind = 2;
    else if (res === er && c === ec && ((f ^ ef) & 5'b00011) == 5'b0) cur.kind = 0;
    else cur.kind = 1;
    cur.op = op; cur.exp = er; cur.act = res;
  endtask

  // corrupt: 0 result bit, 1 carry, 2 compared flag, 3 ignored flag, other = clean
  task automatic drive_alu(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int corrupt);
    logic [31:0] r; logic c; logic [4:0] f; bit sup;
    ref_calc(op, a, b, r, c, f, sup);
    case (corrupt)
      0: r = r ^ (32'h1 << $urandom_range(0, 31));
      1: c = ~c;
      2: f = f ^ (5'h1 << $urandom_range(0, 1));
      3: f = f ^ (5'h1 << $urandom_range(2, 4));
      default: ;
    endcase
    drive_raw(op, a, b, r, c, f);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic resolve(input int i, input sample_t s);
    int max_cnt;
    max_cnt = (i == 0) ? 65535 : 15;
    if (s.kind == 2) begin
      if (m_skip[i] < max_cnt) m_skip[i]++;
    end else if (s.kind == 0) begin
      if (m_pass[i] < max_cnt) m_pass[i]++;
    end else begin
      if (m_fail[i] < max_cnt) m_fail[i]++;
      if (!m_fv[i]) begin
        m_fv[i] = 1'b1; m_fop[i] = s.op; m_fexp[i] = s.exp; m_fact[i] = s.act;
      end
      if (i == 0) m_halt[i] = 1'b1;
    end
  endtask

  // One clock: the model retires the samples accepted last edge, then takes the new one.
  task automatic tick();
    bit      acc[2];
    bit      clr;
    sample_t keep[$];
    sample_t s;
    for (int i = 0; i < 2; i++) acc[i] = in_valid && !m_halt[i];
    clr = clear;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      keep = {};
      foreach (pend_q[k]) begin
        if (pend_q[k].inst != i) keep.push_back(pend_q[k]);
        else if (!clr) resolve(i, pend_q[k]);
      end
      pend_q = keep;
      if (clr) model_zero(i);
      else if (acc[i]) begin
        s = cur; s.inst = i;
        pend_q.push_back(s);
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      total++; if (o_pass[i] !== 32'd0) begin bad++; $display("FAIL reset_pass inst%0d got=%0h exp=0", i, o_pass[i]); end
      total++; if (o_fail[i] !== 32'd0) begin bad++; $display("FAIL reset_fail inst%0d got=%0h exp=0", i, o_fail[i]); end
      total++; if (o_skip[i] !== 32'd0) begin bad++; $display("FAIL reset_skip inst%0d got=%0h exp=0", i, o_skip[i]); end
      total++; if (o_fv[i] !== 1'b0) begin bad++; $display("FAIL reset_fail_valid inst%0d got=%0b exp=0", i, o_fv[i]); end
      total++; if (o_halt[i] !== 1'b0) begin bad++; $display("FAIL reset_halted inst%0d got=%0b exp=0", i, o_halt[i]); end
      total++; if (o_ready[i] !== 1'b1) begin bad++; $display("FAIL reset_in_ready inst%0d got=%0b exp=1", i, o_ready[i]); end
    end
  endtask

  task automatic test_add_pass();
    drive_raw(7'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 5'b01001);
    tick();
    idle();
    total++; if (o_pass[0] !== 32'd0) begin bad++; $display("FAIL add_latency got=%0h exp=0", o_pass[0]); end
    tick();
    for (int i = 0; i < 2; i++) begin
      total++; if (o_pass[i] !== 32'd1) begin bad++; $display("FAIL add_pass inst%0d got=%0h exp=1", i, o_pass[i]); end
      total++; if (o_fv[i] !== 1'b0) begin bad++; $display("FAIL add_fail_valid inst%0d got=%0b exp=0", i, o_fv[i]); end
    end
  endtask

  task automatic test_sub_fail();
    drive_raw(7'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b1, 5'b00010);
    tick();
    idle();
    tick();
    for (int i = 0; i < 2; i++) begin
      total++; if (o_fail[i] !== 32'd1) begin bad++; $display("FAIL sub_fail_count inst%0d got=%0h exp=1", i, o_fail[i]); end
      total++; if (o_fop[i] !== 7'd1) begin bad++; $display("FAIL sub_fail_opcode inst%0d got=%0h exp=1", i, o_fop[i]); end
      total++; if (o_fexp[i] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_fail_expected inst%0d got=%0h exp=fffffffe", i, o_fexp[i]); end
    end
    total++; if (halt0 !== 1'b1) begin bad++; $display("FAIL sub_halted got=%0b exp=1", halt0); end
    total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL sub_in_ready_halt got=%0b exp=0", ready0); end
    total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL sub_in_ready_nostop got=%0b exp=1", ready1); end
  endtask

  task automatic test_skip_clear();
    drive_raw(7'h55, $urandom, $urandom, $urandom, 1'b0, 5'h0);
    tick();
    idle();
    tick();
    total++; if (o_skip[1] !== 32'd1) begin bad++; $display("FAIL skip_count got=%0h exp=1", o_skip[1]); end
    total++; if (o_pass[1] !== 32'd1) begin bad++; $display("FAIL skip_pass_kept got=%0h exp=1", o_pass[1]); end
    total++; if (o_fail[1] !== 32'd1) begin bad++; $display("FAIL skip_fail_kept got=%0h exp=1", o_fail[1]); end
    total++; if (o_skip[0] !== 32'd0) begin bad++; $display("FAIL skip_while_halted got=%0h exp=0", o_skip[0]); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (o_pass[i] !== 32'd0 || o_fail[i] !== 32'd0 || o_skip[i] !== 32'd0)
        begin bad++; $display("FAIL clear_counters inst%0d got=%0h/%0h/%0h exp=0/0/0", i, o_pass[i], o_fail[i], o_skip[i]); end
      total++; if (o_halt[i] !== 1'b0 || o_fv[i] !== 1'b0)
        begin bad++; $display("FAIL clear_state inst%0d halted=%0b fail_valid=%0b exp=0/0", i, o_halt[i], o_fv[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, bad_val;
    bad_val = '0;
    for (int n = 0; n < 10; n++) begin
      a = $urandom; b = $urandom;
      if (n == 2) begin
        bad_val = (a & b) ^ 32'h0000_0100;
        drive_raw(7'd2, a, b, bad_val, 1'b0, {~^bad_val, 1'b0, 1'b0, bad_val[31], bad_val == 0});
      end else drive_alu(7'd2, a, b, 9);
      tick();
      total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL b2b_in_ready n%0d got=%0b exp=1", n, ready1); end
    end
    idle();
    tick(); tick();
    total++; if (o_pass[1] !== 32'd9) begin bad++; $display("FAIL b2b_pass got=%0h exp=9", o_pass[1]); end
    total++; if (o_fail[1] !== 32'd1) begin bad++; $display("FAIL b2b_fail got=%0h exp=1", o_fail[1]); end
    total++; if (o_fact[1] !== bad_val) begin bad++; $display("FAIL b2b_fail_actual got=%0h exp=%0h", o_fact[1], bad_val); end
    total++; if (o_pass[0] !== 32'(m_pass[0])) begin bad++; $display("FAIL b2b_pass_halting got=%0h exp=%0h", o_pass[0], m_pass[0]); end
    total++; if (o_halt[0] !== m_halt[0]) begin bad++; $display("FAIL b2b_halted got=%0b exp=%0b", o_halt[0], m_halt[0]); end
  endtask

  task automatic test_saturate();
    clear = 1'b1; tick(); clear = 1'b0;
    for (int n = 0; n < 16; n++) begin
      drive_alu(7'd0, $urandom, $urandom, 9);
      tick();
    end
    idle(); tick(); tick();
    total++; if (o_pass[1] !== 32'hF) begin bad++; $display("FAIL sat_at_16 got=%0h exp=f", o_pass[1]); end
    drive_alu(7'd3, $urandom, $urandom, 9);
    tick(); idle(); tick();
    total++; if (o_pass[1] !== 32'hF) begin bad++; $display("FAIL sat_at_17 got=%0h exp=f", o_pass[1]); end
    total++; if (o_pass[0] !== 32'd17) begin bad++; $display("FAIL sat_wide got=%0h exp=11", o_pass[0]); end
  endtask

  task automatic test_random();
    clear = 1'b1; tick(); clear = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 4) != 0)
        drive_alu(7'($urandom_range(0, 11)), $urandom, $urandom, $urandom_range(0, 7));
      else idle();
      tick();
      for (int i = 0; i < 2; i++) begin
        total++; if (o_pass[i] !== 32'(m_pass[i])) begin bad++; $display("FAIL rnd_pass inst%0d cyc%0d got=%0h exp=%0h", i, cyc, o_pass[i], m_pass[i]); end
        total++; if (o_fail[i] !== 32'(m_fail[i])) begin bad++; $display("FAIL rnd_fail inst%0d cyc%0d got=%0h exp=%0h", i, cyc, o_fail[i], m_fail[i]); end
        total++; if (o_skip[i] !== 32'(m_skip[i])) begin bad++; $display("FAIL rnd_skip inst%0d cyc%0d got=%0h exp=%0h", i, cyc, o_skip[i], m_skip[i]); end
        total++; if (o_fv[i] !== m_fv[i]) begin bad++; $display("FAIL rnd_fail_valid inst%0d cyc%0d got=%0b exp=%0b", i, cyc, o_fv[i], m_fv[i]); end
        total++; if (o_ready[i] !== !m_halt[i]) begin bad++; $display("FAIL rnd_in_ready inst%0d cyc%0d got=%0b exp=%0b", i, cyc, o_ready[i], !m_halt[i]); end
        if (m_fv[i]) begin
          total++; if (o_fop[i] !== m_fop[i] || o_fexp[i] !== m_fexp[i] || o_fact[i] !== m_fact[i])
            begin bad++; $display("FAIL rnd_capture inst%0d cyc%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, cyc, o_fop[i], o_fexp[i], o_fact[i], m_fop[i], m_fexp[i], m_fact[i]); end
        end
      end
    end
    clear = 1'b0;
    idle();
  endtask

  task automatic test_reset_inflight();
    clear = 1'b1; tick(); clear = 1'b0;
    drive_alu(7'd4, $urandom, $urandom, 9);
    tick();
    drive_alu(7'd9, $urandom, $urandom, 9);
    #2 rst_n = 1'b0;
    model_zero(0); model_zero(1); pend_q.delete();
    #1;
    total++; if (o_pass[0] !== 32'd0 || o_pass[1] !== 32'd0) begin bad++; $display("FAIL rst_async_pass got=%0h/%0h exp=0/0", o_pass[0], o_pass[1]); end
    idle();
    @(posedge clk); #1 rst_n = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 2; i++) begin
      total++; if (o_pass[i] !== 32'd0 || o_fail[i] !== 32'd0 || o_skip[i] !== 32'd0)
        begin bad++; $display("FAIL rst_no_update inst%0d got=%0h/%0h/%0h exp=0/0/0", i, o_pass[i], o_fail[i], o_skip[i]); end
      total++; if (o_ready[i] !== 1'b1) begin bad++; $display("FAIL rst_in_ready inst%0d got=%0b exp=1", i, o_ready[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_add_pass();
    test_sub_fail();
    test_skip_clear();
    test_back_to_back();
    test_saturate();
    test_random();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
